// File: rtl/fft_frame_sched.sv
// ============================================================================
// fft_frame_sched : frame scheduler for the pipelined FFT datapath
// Opens a frame on start, admits BLK_PER_FRAME beats, tracks the datapath
// latency and flags out_valid / out_last / done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_frame_sched #(
  parameter int BLK_PER_FRAME = 32,
  parameter int NUM_STG       = 5,
  parameter int PIPE_LAT      = 10,
  parameter int ALERT_MOD     = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             busy,
  output logic [NUM_STG-1:0]               stg_sel,
  output logic [$clog2(BLK_PER_FRAME)-1:0] beat_idx,
  output logic                             beat_en,
  output logic                             alert_mod10,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             done
);

  localparam int IDX_W = $clog2(BLK_PER_FRAME);
  localparam int ALT_W = $clog2(ALERT_MOD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_PER_FRAME - 1);
  localparam logic [ALT_W-1:0] ALT_TOP  = ALT_W'(ALERT_MOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                done_nxt;
  logic [IDX_W-1:0]    beat_cnt;
  logic [ALT_W-1:0]    alt_cnt;
  logic [PIPE_LAT-1:0] vld_line;
  logic [PIPE_LAT-1:0] last_line;
  logic                accept;
  logic                last_beat;

  // in_ready is only ever high in LOAD, so it alone qualifies acceptance
  assign accept    = in_valid & in_ready & ~abort;
  assign last_beat = accept & (beat_cnt == LAST_IDX);
  assign busy      = (state != IDLE);
  assign out_valid = vld_line[PIPE_LAT-1];
  assign out_last  = last_line[PIPE_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    if (last_beat) state_nxt = DRAIN;
        DRAIN: begin
          if (out_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b0;
      done        <= 1'b0;
      beat_en     <= 1'b0;
      alert_mod10 <= 1'b0;
      beat_idx    <= '0;
      stg_sel     <= '0;
      beat_cnt    <= '0;
      alt_cnt     <= '0;
      vld_line    <= '0;
      last_line   <= '0;
    end else if (abort) begin
      in_ready    <= 1'b0;
      done        <= 1'b0;
      beat_en     <= 1'b0;
      alert_mod10 <= 1'b0;
      beat_idx    <= '0;
      stg_sel     <= '0;
      beat_cnt    <= '0;
      alt_cnt     <= '0;
      vld_line    <= '0;
      last_line   <= '0;
    end else begin
      in_ready    <= (state_nxt == LOAD);
      done        <= done_nxt;
      beat_en     <= accept;
      alert_mod10 <= accept & (alt_cnt == ALT_TOP);
      vld_line    <= (vld_line << 1) | PIPE_LAT'(accept);
      last_line   <= (last_line << 1) | PIPE_LAT'(last_beat);
      if (state == IDLE && start) begin
        beat_cnt <= '0;
        alt_cnt  <= '0;
      end else if (accept) begin
        beat_idx <= beat_cnt;
        stg_sel  <= NUM_STG'(beat_cnt);
        beat_cnt <= beat_cnt + 1'b1;
        alt_cnt  <= (alt_cnt == ALT_TOP) ? '0 : alt_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
